// File: rtl/key_pkg.sv
// Shared definitions for the key bounce generator: FSM state codes,
// the LFSR feedback taps, the default LFSR seed and the LFSR step function.
package key_pkg;

  localparam int          STATE_W    = 3;
  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_PRESS_B = 3'd1;
  localparam logic [2:0]  ST_HOLD    = 3'd2;
  localparam logic [2:0]  ST_REL_B   = 3'd3;
  localparam logic [2:0]  ST_DONE    = 3'd4;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One LFSR step: feedback (XOR of tapped bits) enters at the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the bounce-length source.
// Loads SEED on reset; SEED must be nonzero or the sequence locks up.
module lfsr16
  import key_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // Advance one step every cycle, regardless of what the consumer is doing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEED;
    else     state <= lfsr_step(state);
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: on req, drives key_out through a press-bounce
// burst, a stable hold of hold_len cycles and a release-bounce burst, then
// pulses done. key_out: 1 = pressed, 0 = released.
// Build option KEY_BOUNCE_FIXED_EN: every bounce segment is BOUNCE_MAX+1
// cycles and no LFSR is built; otherwise lengths come from lfsr16.
module key_bounce_gen
  import key_pkg::*;
#(
  parameter int          BOUNCE_NUM = 4,
  parameter int          BOUNCE_MAX = 255,
  parameter int          HOLD_W     = 16,
  parameter logic [15:0] SEED       = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              busy,
  output logic              done,
  output logic              key_out
);

  // Segments per bounce phase; kept >= 1 so widths stay legal when bouncing is off.
  localparam int               SEG_TOTAL = (BOUNCE_NUM > 0) ? 2 * BOUNCE_NUM : 1;
  localparam int               IDX_W     = (SEG_TOTAL > 1) ? $clog2(SEG_TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEG_TOTAL - 1);

  logic [STATE_W-1:0] state_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic [8:0]         seg_left_reg;   // remaining cycles of current segment, valid after its first cycle
  logic               seg_first_reg;  // current cycle is the first of a segment
  logic [IDX_W-1:0]   seg_idx_reg;

  logic [8:0]         seg_draw;
  logic [8:0]         seg_len_now;
  logic               seg_last;
  logic               idx_last;

`ifdef KEY_BOUNCE_FIXED_EN
  assign seg_draw = 9'(BOUNCE_MAX + 1);
`else
  logic [15:0] lfsr_state;
  logic        lfsr_unused;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  // Only the low byte feeds the length draw.
  assign lfsr_unused = ^lfsr_state[15:8];
  assign seg_draw    = {1'b0, lfsr_state[7:0] & 8'(BOUNCE_MAX)} + 9'd1;
`endif

  // In a segment's first cycle its length is the fresh draw; afterwards the stored remainder.
  assign seg_len_now = seg_first_reg ? seg_draw : seg_left_reg;
  assign seg_last    = (seg_len_now == 9'd1);
  assign idx_last    = (seg_idx_reg == LAST_IDX);

  // Sequencer: walks the phases and registers key_out/busy/done together with each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      hold_cnt_reg  <= '0;
      seg_left_reg  <= '0;
      seg_first_reg <= 1'b0;
      seg_idx_reg   <= '0;
      key_out       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            hold_cnt_reg  <= (hold_len == '0) ? HOLD_W'(1) : hold_len;
            busy          <= 1'b1;
            key_out       <= 1'b1;
            seg_idx_reg   <= '0;
            seg_first_reg <= 1'b1;
            state_reg     <= (BOUNCE_NUM == 0) ? ST_HOLD : ST_PRESS_B;
          end
        end

        ST_PRESS_B, ST_REL_B: begin
          if (!seg_last) begin
            seg_left_reg  <= seg_len_now - 9'd1;
            seg_first_reg <= 1'b0;
          end else begin
            seg_first_reg <= 1'b1;
            if (!idx_last) begin
              seg_idx_reg <= seg_idx_reg + IDX_W'(1);
              // Next index k+1: press is high on even k, release is high on odd k.
              key_out     <= (state_reg == ST_PRESS_B) ? seg_idx_reg[0] : ~seg_idx_reg[0];
            end else if (state_reg == ST_PRESS_B) begin
              seg_idx_reg <= '0;
              state_reg   <= ST_HOLD;
              key_out     <= 1'b1;
            end else begin
              state_reg   <= ST_DONE;
              key_out     <= 1'b0;
              done        <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (hold_cnt_reg == HOLD_W'(1)) begin
            seg_idx_reg   <= '0;
            seg_first_reg <= 1'b1;
            key_out       <= 1'b0;
            if (BOUNCE_NUM == 0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_REL_B;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          key_out   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
Synthesizable mechanical-key emulator. It is the driving end of the push-key interface.
- On request, drives a key line through a press-bounce burst, a stable hold and a release-bounce burst.
- Used in benches and on-board self-test to exercise the team's debouncer without a physical button.
- key_out follows the key convention used by our debouncer input: 1 = pressed, 0 = released/idle.

Parameters:
BOUNCE_NUM, 4, glitch pairs per bounce phase; 0 disables both bounce phases.
BOUNCE_MAX, 255, mask on the 8-bit segment-length draw; segment length = (draw & BOUNCE_MAX) + 1 cycles.
HOLD_W, 16, width of hold_len.
SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  start request, sampled only in IDLE
hold_len  in  HOLD_W  stable-pressed duration in cycles; latched on accepted req; 0 treated as 1
busy  out  1  high from cycle after accepted req until the done cycle inclusive
done  out  1  one-cycle pulse, sequence complete
key_out  out  1  emulated key level

Behaviour:
- Reset (async, immediate): key_out=0, busy=0, done=0, state=IDLE, lfsr=SEED, counters=0. Reset mid-sequence returns key_out to 0 at once; no done pulse is issued.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in all states.
- Segment length: drawn from lfsr[7:0] at the first cycle of each segment.
- States:
  - IDLE: key_out=0, busy=0. req=1 latches hold_len (0 becomes 1) and moves to PRESS_B, or to HOLD if BOUNCE_NUM=0.
  - PRESS_B: 2*BOUNCE_NUM segments, index k=0..2N-1. Level = 1 for even k, 0 for odd k. After the last segment, go to HOLD.
  - HOLD: key_out=1 for exactly hold_len cycles, then go to REL_B, or to DONE if BOUNCE_NUM=0.
  - REL_B: 2*BOUNCE_NUM segments. Level = 0 for even k, 1 for odd k. After the last segment, go to DONE.
  - DONE: key_out=0, done=1, busy=1 for one cycle, then IDLE.
- Latency: key_out first changes in the cycle after the edge that accepted req. No idle gap between phases.
- req while busy: ignored, not queued. req held high continuously restarts a sequence on the cycle after DONE.
- hold_len changes while busy: no effect.
- Segment counter is 9 bits (max 256), with no wrap. The hold counter is HOLD_W bits and counts down to 1.
- Outputs are registered; no combinational path from req to key_out.

Optional Feature:
Macro: KEY_BOUNCE_FIXED_EN.
- Defined: every segment length is exactly BOUNCE_MAX+1 cycles and the LFSR is not instantiated. The waveform is fully deterministic for directed tests.
- Undefined: segment lengths are pseudo-random via the LFSR as above.
- State sequence and all other timing are identical in both builds.

Decomposition:
- Shared package key_pkg: state encoding constants (IDLE=0, PRESS_B=1, HOLD=2, REL_B=3, DONE=4, width 3), LFSR tap mask, default SEED.
- One sub-module: lfsr16 (clk, rst, seed parameter, 16-bit state out, free-running). It is omitted under KEY_BOUNCE_FIXED_EN.
- The FSM and counters stay in key_bounce_gen.

Test Plan:
1. FIXED_EN, BOUNCE_NUM=2, BOUNCE_MAX=3, req pulse with hold_len=100 -> key_out pattern 1,0,1,0 (4 cycles each), then 1 for 100 cycles, then 0,1,0,1 (4 cycles each). done pulses 133 cycles after req is sampled, with key_out=0. busy is high for 133 cycles.
2. FIXED_EN, BOUNCE_NUM=0, hold_len=0 -> key_out=1 for exactly 1 cycle, then done the next cycle; total busy is 2 cycles.
3. req re-pulsed at cycles 10 and 50 during a running sequence -> no restart, single done. req held high -> a new sequence starts the cycle after done.
4. rst asserted mid-HOLD -> key_out=0, busy=0 in the same cycle with no clock needed; no done. After release, lfsr=16'hACE1 and a new req behaves like scenario 1.
5. Random build, BOUNCE_MAX=255, 1000 sequences -> every segment length is in 1..256, each phase has exactly 2*BOUNCE_NUM transitions, and the hold length is exact.
6. Loopback into the downstream debouncer (sim wait 10000 cycles) -> hold_len=20000 gives exactly one debounced pulse per sequence; hold_len=5000 gives zero pulses.
